// File: rtl/rgb2raw_bayer_tx.sv
// rgb2raw_bayer_tx
//
// Re-mosaicing transmitter. It takes an 8-bit-per-channel RGB pixel stream in
// VGA timing and emits a 10-bit single-channel Bayer RAW stream with frame,
// line and pixel valid strobes. It is the inverse of the RAW-to-RGB demosaic
// path, so a frame pushed through here and then through the demosaic chain
// comes back as (approximately) the original picture.
//
// Ports
//   VGA_CLK       sole clock, rising edge
//   RST           asynchronous, active-high reset
//   iRed/iGreen/iBlue  8-bit input samples
//   READ_Request  input pixel valid (data enable)
//   VGA_VS        vertical sync, active low; its falling edge starts a frame
//   VGA_HS        horizontal sync, active low; only used for the line-edge check
//   oDATA         10-bit Bayer RAW sample
//   oDVAL         oDATA valid
//   oLVAL         line valid
//   oFVAL         frame valid
//   oX, oY        column / row of the current oDATA
//   oOVF          sticky overrun flag, cleared at each frame start
//
// Every output is two clocks behind the input that produced it.

module rgb2raw_bayer_tx #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter logic [1:0] BAYER_PHASE = 2'b00
) (
    input  logic        VGA_CLK,
    input  logic        RST,
    input  logic [7:0]  iRed,
    input  logic [7:0]  iGreen,
    input  logic [7:0]  iBlue,
    input  logic        READ_Request,
    input  logic        VGA_VS,
    input  logic        VGA_HS,
    output logic [9:0]  oDATA,
    output logic        oDVAL,
    output logic        oLVAL,
    output logic        oFVAL,
    output logic [10:0] oX,
    output logic [10:0] oY,
    output logic        oOVF
);

    localparam logic [10:0] H_LIMIT   = 11'(H_ACTIVE);
    localparam logic [10:0] LAST_LINE = 11'(V_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_DONE
    } stateType;

    stateType    state;
    stateType    stateNext;

    logic        vsPrev;
    logic        reqPrev;
    logic [10:0] xCnt;
    logic [10:0] yCnt;

    logic        frameStart;
    logic        lineEnd;
    logic        inFrame;
    logic        xInRange;
    logic        accept;
    logic        overrun;
    logic        edgeErr;

    logic        s1Valid;
    logic [7:0]  s1Red;
    logic [7:0]  s1Green;
    logic [7:0]  s1Blue;
    logic [10:0] s1X;
    logic [10:0] s1Y;
    logic        s1Fval;
    logic        s1Fs;
    logic        s1Ovf;

    logic [1:0]  cfaPos;
    logic [7:0]  chanSel;

    // Event decode for the current cycle. A frame start always wins over a
    // pixel arriving in the same cycle, so the pixel is neither accepted nor
    // allowed to flag an overrun against the counters it is about to clear.
    always_comb begin
        frameStart = vsPrev & ~VGA_VS;
        lineEnd    = reqPrev & ~READ_Request;
        inFrame    = (state == S_FRAME);
        xInRange   = (xCnt < H_LIMIT);
        accept     = READ_Request & inFrame & xInRange & ~frameStart;
        overrun    = READ_Request & inFrame & ~xInRange & ~frameStart;
        edgeErr    = READ_Request & ~VGA_HS & inFrame & ~frameStart;
    end

    // Frame state decision. S_DONE parks the block after the last line so a
    // stray extra line cannot wrap the row counter back into the frame.
    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: begin
                if (frameStart) stateNext = S_FRAME;
            end
            S_FRAME: begin
                if (frameStart)                           stateNext = S_FRAME;
                else if (lineEnd && (yCnt == LAST_LINE))  stateNext = S_DONE;
            end
            S_DONE: begin
                if (frameStart) stateNext = S_FRAME;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // State register plus the sync/enable history used for edge detection.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            vsPrev  <= 1'b0;
            reqPrev <= 1'b0;
        end else begin
            state   <= stateNext;
            vsPrev  <= VGA_VS;
            reqPrev <= READ_Request;
        end
    end

    // Pixel position counters. The end of a line is the falling edge of the
    // data enable; an overrun pixel leaves the column counter where it is.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (frameStart) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (inFrame) begin
            if (lineEnd) begin
                xCnt <= '0;
                yCnt <= yCnt + 11'd1;
            end else if (accept) begin
                xCnt <= xCnt + 11'd1;
            end
        end
    end

    // Stage 1: capture the accepted pixel with its position, and carry the
    // frame-valid and overrun events alongside it so they stay aligned with
    // the data all the way to the outputs.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            s1Valid <= 1'b0;
            s1Red   <= '0;
            s1Green <= '0;
            s1Blue  <= '0;
            s1X     <= '0;
            s1Y     <= '0;
            s1Fval  <= 1'b0;
            s1Fs    <= 1'b0;
            s1Ovf   <= 1'b0;
        end else begin
            s1Valid <= accept;
            s1Fval  <= (stateNext == S_FRAME);
            s1Fs    <= frameStart;
            s1Ovf   <= overrun | edgeErr;
            if (accept) begin
                s1Red   <= iRed;
                s1Green <= iGreen;
                s1Blue  <= iBlue;
                s1X     <= xCnt;
                s1Y     <= yCnt;
            end
        end
    end

    // Colour filter position: the sensor mosaic is G R / B G with the phase
    // parameter flipping rows and/or columns to match other sensor readouts.
    always_comb begin
        cfaPos = {s1Y[0], s1X[0]} ^ BAYER_PHASE;
        case (cfaPos)
            2'b01:   chanSel = s1Red;
            2'b10:   chanSel = s1Blue;
            default: chanSel = s1Green;
        endcase
    end

    // Stage 2: widen to 10 bits by replicating the top bits into the new
    // LSBs so full scale stays full scale. The line strobe follows the
    // accepted pixels because a line never has gaps; once a line overruns,
    // the strobe drops with the first dropped pixel.
    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
            oLVAL <= 1'b0;
            oFVAL <= 1'b0;
            oX    <= '0;
            oY    <= '0;
            oOVF  <= 1'b0;
        end else begin
            oDVAL <= s1Valid;
            oLVAL <= s1Valid;
            oFVAL <= s1Fval;
            if (s1Valid) begin
                oDATA <= {chanSel, chanSel[7:6]};
                oX    <= s1X;
                oY    <= s1Y;
            end
            if (s1Fs) begin
                oOVF <= 1'b0;
            end else if (s1Ovf) begin
                oOVF <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb2raw_bayer_tx.sv
// tb_rgb2raw_bayer_tx
//
// Bench for rgb2raw_bayer_tx. Two instances share one stimulus stream, one
// with the default Bayer phase and one with both flips set. A cycle-level
// reference model written from the mosaic rules predicts every output two
// clocks later, and directed tests pin that model with literal values.

module tb_rgb2raw_bayer_tx;

    localparam int H = 16;
    localparam int V = 6;

    logic        VGA_CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  iRed = '0;
    logic [7:0]  iGreen = '0;
    logic [7:0]  iBlue = '0;
    logic        READ_Request = 1'b0;
    logic        VGA_VS = 1'b1;
    logic        VGA_HS = 1'b1;

    logic [9:0]  data0, data3;
    logic        dval0, dval3, lval0, lval3, fval0, fval3, ovf0, ovf3;
    logic [10:0] x0, y0, x3, y3;

    rgb2raw_bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .BAYER_PHASE(2'b00)) dut0 (
        .VGA_CLK(VGA_CLK), .RST(RST),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .READ_Request(READ_Request), .VGA_VS(VGA_VS), .VGA_HS(VGA_HS),
        .oDATA(data0), .oDVAL(dval0), .oLVAL(lval0), .oFVAL(fval0),
        .oX(x0), .oY(y0), .oOVF(ovf0)
    );

    rgb2raw_bayer_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .BAYER_PHASE(2'b11)) dut3 (
        .VGA_CLK(VGA_CLK), .RST(RST),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .READ_Request(READ_Request), .VGA_VS(VGA_VS), .VGA_HS(VGA_HS),
        .oDATA(data3), .oDVAL(dval3), .oLVAL(lval3), .oFVAL(fval3),
        .oX(x3), .oY(y3), .oOVF(ovf3)
    );

    // 100 MHz-style free-running clock
    initial forever #5 VGA_CLK = ~VGA_CLK;

    int errCount = 0;
    int checkCount = 0;
    int dvalCount = 0;

    typedef struct {
        int dval;
        int fval;
        int ovf;
        int d0;
        int d3;
        int x;
        int y;
    } expT;

    typedef struct {
        int d0;
        int d3;
        int x;
        int y;
    } recT;

    expT pipeA = '{default: 0};
    expT pipeB = '{default: 0};
    recT rec[$];

    int  mState = 0;
    int  mX = 0;
    int  mY = 0;
    int  mOvf = 0;
    bit  prevVs = 1'b0;
    bit  prevReq = 1'b0;

    // One comparison: counts it, and reports a mismatch on one line
    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // 8 -> 10 bit widening, written as plain arithmetic
    function automatic int expandM(input int c);
        return c * 4 + c / 64;
    endfunction

    // Which sample a sensor site sees: greens sit where row and column
    // parity agree, red on even (flipped) rows, blue on odd ones
    function automatic int pickM(input int x, input int y, input int phase,
                                 input int r, input int g, input int b);
        int colOdd;
        int rowOdd;
        colOdd = (x % 2) ^ (phase % 2);
        rowOdd = (y % 2) ^ (phase / 2);
        if (colOdd == rowOdd) return expandM(g);
        if (rowOdd == 0)      return expandM(r);
        return expandM(b);
    endfunction

    // Reference model: frame/line bookkeeping per input cycle, with the
    // predictions held in a two-deep delay line to match output latency
    always @(posedge VGA_CLK) begin
        expT e;
        bit  fs, lineEnd, acc, evt;
        if (RST) begin
            mState = 0; mX = 0; mY = 0; mOvf = 0;
            prevVs = 1'b0; prevReq = 1'b0;
            pipeA = '{default: 0};
            pipeB = '{default: 0};
        end else begin
            fs      = prevVs && !VGA_VS;
            lineEnd = prevReq && !READ_Request;
            acc     = READ_Request && (mState == 1) && (mX < H) && !fs;
            evt     = READ_Request && (mState == 1) && !fs && ((mX >= H) || !VGA_HS);
            e.dval  = acc;
            e.x     = mX;
            e.y     = mY;
            e.d0    = pickM(mX, mY, 0, iRed, iGreen, iBlue);
            e.d3    = pickM(mX, mY, 3, iRed, iGreen, iBlue);
            if (fs) begin
                mX = 0; mY = 0; mOvf = 0; mState = 1;
            end else begin
                if (evt) mOvf = 1;
                if (mState == 1) begin
                    if (lineEnd) begin
                        if (mY == V - 1) mState = 2;
                        mX = 0;
                        mY = mY + 1;
                    end else if (acc) begin
                        mX = mX + 1;
                    end
                end
            end
            e.fval  = (mState == 1);
            e.ovf   = mOvf;
            prevVs  = VGA_VS;
            prevReq = READ_Request;
            pipeB   = pipeA;
            pipeA   = e;
        end
    end

    // Compare DUT outputs with the model on every cycle out of reset, and
    // log each valid sample for the directed checks
    always @(negedge VGA_CLK) begin
        if (!RST) begin
            checkOutput("oDVAL", dval0, pipeB.dval);
            checkOutput("oLVAL", lval0, pipeB.dval);
            checkOutput("oFVAL", fval0, pipeB.fval);
            checkOutput("oOVF", ovf0, pipeB.ovf);
            checkOutput("oDVAL_ph3", dval3, pipeB.dval);
            if (pipeB.dval != 0) begin
                checkOutput("oDATA", data0, pipeB.d0);
                checkOutput("oDATA_ph3", data3, pipeB.d3);
                checkOutput("oX", x0, pipeB.x);
                checkOutput("oY", y0, pipeB.y);
            end
            if (dval0) begin
                dvalCount++;
                rec.push_back('{d0: data0, d3: data3, x: x0, y: y0});
            end
        end
    end

    // Frame start: one low cycle on VS, then a short settle
    task automatic frameStart();
        @(negedge VGA_CLK); VGA_VS = 1'b0;
        @(negedge VGA_CLK); VGA_VS = 1'b1;
        repeat (2) @(negedge VGA_CLK);
    endtask

    // One line of n pixels, each channel ramping by step; HS pulses low at
    // pixel hsLow (if >= 0) and in the blanking gap after the line
    task automatic applyStimulus(input int n, input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input int step, input int hsLow);
        for (int i = 0; i < n; i++) begin
            @(negedge VGA_CLK);
            READ_Request = 1'b1;
            iRed   = r + 8'(step * i);
            iGreen = g + 8'(step * i * 3);
            iBlue  = b + 8'(step * i * 5);
            VGA_HS = (i == hsLow) ? 1'b0 : 1'b1;
        end
        @(negedge VGA_CLK);
        READ_Request = 1'b0;
        VGA_HS = 1'b0;
        iRed = '0; iGreen = '0; iBlue = '0;
        @(negedge VGA_CLK);
        VGA_HS = 1'b1;
        repeat (2) @(negedge VGA_CLK);
    endtask

    initial begin
        int base;
        int maxX;
        logic [9:0] expLine0Ph0 [4];
        logic [9:0] expLine1Ph0 [4];
        logic [9:0] expLine0Ph3 [4];
        expLine0Ph0 = '{10'h202, 10'h3FF, 10'h202, 10'h3FF};
        expLine1Ph0 = '{10'h000, 10'h202, 10'h000, 10'h202};
        expLine0Ph3 = '{10'h202, 10'h000, 10'h202, 10'h000};

        // Reset state
        repeat (2) @(negedge VGA_CLK);
        RST = 1'b0;
        checkOutput("reset_oDATA", data0, 0);
        checkOutput("reset_oDVAL", dval0, 0);
        checkOutput("reset_oLVAL", lval0, 0);
        checkOutput("reset_oFVAL", fval0, 0);
        checkOutput("reset_oX", x0, 0);
        checkOutput("reset_oY", y0, 0);
        checkOutput("reset_oOVF", ovf0, 0);
        repeat (3) @(negedge VGA_CLK);

        // Colour pattern on two lines, both phases
        frameStart();
        rec.delete();
        applyStimulus(4, 8'hFF, 8'h80, 8'h00, 0, -1);
        applyStimulus(4, 8'hFF, 8'h80, 8'h00, 0, -1);
        checkOutput("pattern_count", rec.size(), 8);
        if (rec.size() == 8) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("pat_l0_d%0d", i), rec[i].d0, int'(expLine0Ph0[i]));
                checkOutput($sformatf("pat_l0_ph3_d%0d", i), rec[i].d3, int'(expLine0Ph3[i]));
                checkOutput($sformatf("pat_l0_x%0d", i), rec[i].x, i);
                checkOutput($sformatf("pat_l0_y%0d", i), rec[i].y, 0);
                checkOutput($sformatf("pat_l1_d%0d", i), rec[i + 4].d0, int'(expLine1Ph0[i]));
                checkOutput($sformatf("pat_l1_y%0d", i), rec[i + 4].y, 1);
            end
        end
        checkOutput("pattern_fval", fval0, 1);

        // Overrun: two pixels too many in a line
        frameStart();
        rec.delete();
        applyStimulus(H + 2, 8'h10, 8'h20, 8'h30, 3, -1);
        checkOutput("ovr_count", rec.size(), H);
        maxX = 0;
        foreach (rec[i]) if (rec[i].x > maxX) maxX = rec[i].x;
        checkOutput("ovr_maxX", maxX, H - 1);
        checkOutput("ovr_flag", ovf0, 1);
        repeat (5) @(negedge VGA_CLK);
        checkOutput("ovr_sticky", ovf0, 1);
        frameStart();
        checkOutput("ovr_cleared", ovf0, 0);

        // Line-edge check: HS low while the enable is high
        applyStimulus(6, 8'h55, 8'hAA, 8'h0F, 1, 3);
        checkOutput("hs_edge_flag", ovf0, 1);

        // Frame start on top of a pixel mid-line
        frameStart();
        rec.delete();
        applyStimulus(4, 8'hC0, 8'h40, 8'h01, 0, -1);
        for (int i = 0; i < 7; i++) begin
            @(negedge VGA_CLK);
            READ_Request = 1'b1;
            iRed = 8'hC0; iGreen = 8'h40; iBlue = 8'h01;
            VGA_VS = (i == 3) ? 1'b0 : 1'b1;
        end
        @(negedge VGA_CLK);
        READ_Request = 1'b0;
        VGA_VS = 1'b1;
        repeat (3) @(negedge VGA_CLK);
        checkOutput("fsmid_count", rec.size(), 10);
        if (rec.size() == 10) begin
            checkOutput("fsmid_before_x", rec[6].x, 2);
            checkOutput("fsmid_before_y", rec[6].y, 1);
            checkOutput("fsmid_first_x", rec[7].x, 0);
            checkOutput("fsmid_first_y", rec[7].y, 0);
            checkOutput("fsmid_first_d", rec[7].d0, 10'h101);
            checkOutput("fsmid_next_d", rec[8].d0, 10'h303);
            checkOutput("fsmid_next_ph3_d", rec[8].d3, 10'h004);
        end

        // Full frame, then one line too many
        frameStart();
        rec.delete();
        base = dvalCount;
        for (int l = 0; l < V; l++) applyStimulus(H, 8'(l * 17), 8'(l * 9 + 1), 8'(l * 5 + 2), 7, -1);
        checkOutput("frame_dval_total", dvalCount - base, H * V);
        if (rec.size() > 0) begin
            checkOutput("frame_last_x", rec[rec.size() - 1].x, H - 1);
            checkOutput("frame_last_y", rec[rec.size() - 1].y, V - 1);
        end
        checkOutput("frame_done_fval", fval0, 0);
        base = dvalCount;
        applyStimulus(H, 8'h11, 8'h22, 8'h33, 1, -1);
        checkOutput("extra_line_dval", dvalCount - base, 0);
        checkOutput("extra_line_fval", fval0, 0);

        // Asynchronous reset in the middle of a line
        frameStart();
        for (int i = 0; i < 5; i++) begin
            @(negedge VGA_CLK);
            READ_Request = 1'b1;
            iRed = 8'hFF; iGreen = 8'hFF; iBlue = 8'hFF;
        end
        @(posedge VGA_CLK);
        #2 RST = 1'b1;
        #1;
        checkOutput("arst_oDATA", data0, 0);
        checkOutput("arst_oDVAL", dval0, 0);
        checkOutput("arst_oLVAL", lval0, 0);
        checkOutput("arst_oFVAL", fval0, 0);
        checkOutput("arst_oX", x0, 0);
        checkOutput("arst_oY", y0, 0);
        checkOutput("arst_oOVF", ovf0, 0);
        @(negedge VGA_CLK);
        READ_Request = 1'b0;
        @(negedge VGA_CLK);
        RST = 1'b0;
        base = dvalCount;
        applyStimulus(6, 8'h21, 8'h43, 8'h65, 2, -1);
        checkOutput("after_rst_no_dval", dvalCount - base, 0);
        checkOutput("after_rst_no_fval", fval0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errCount + 1, checkCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/rgb2raw_bayer_tx.md
# rgb2raw_bayer_tx

Re-mosaicing transmitter: takes the 8-bit-per-channel RGB pixel stream in VGA timing and emits a 10-bit single-channel Bayer RAW stream with frame, line and pixel valid strobes. It is the inverse of the RAW-to-RGB demosaic path and sits in front of the line-buffer/demosaic chain. Typical uses:
- feeding the D8M processing path from synthetic or stored RGB frames;
- loop-back verification of the demosaic path.

## Interface
Parameters:
- H_ACTIVE, 640: maximum valid pixels per line.
- V_ACTIVE, 480: valid lines per frame.
- BAYER_PHASE, 2'b00: {Y-flip, X-flip} XORed into the pixel parity before channel selection.

Ports:
- VGA_CLK  in  1  sole clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iRed  in  8  red sample.
- iGreen  in  8  green sample.
- iBlue  in  8  blue sample.
- READ_Request  in  1  input pixel valid (data enable).
- VGA_VS  in  1  vertical sync, active low.
- VGA_HS  in  1  horizontal sync, active low; used only for the line-edge check.
- oDATA  out  10  Bayer RAW sample.
- oDVAL  out  1  oDATA valid.
- oLVAL  out  1  line valid.
- oFVAL  out  1  frame valid.
- oX  out  11  column of the current oDATA.
- oY  out  11  row of the current oDATA.
- oOVF  out  1  sticky overrun flag; cleared at each frame start.

## Operation
- Frame-start event (FS): VGA_VS was 1 on the previous cycle and is 0 now. Detection uses one registered copy of VGA_VS.
- State machine, reset state S_IDLE:
  - S_IDLE: outputs quiet. On FS → S_FRAME.
  - S_FRAME: X/Y counting active. When a line ends with Y == V_ACTIVE-1 → S_DONE. On FS → restart S_FRAME with counters cleared.
  - S_DONE: READ_Request ignored. On FS → S_FRAME.
- Counters (11 bits each):
  - X increments on each accepted pixel.
  - Line end = READ_Request falling edge (registered); at line end X ← 0 and Y ← Y+1.
  - FS clears X, Y and oOVF.
- Accepted pixel: READ_Request=1, state S_FRAME, X < H_ACTIVE, and no FS this cycle.
- Overrun: READ_Request=1 in S_FRAME with X ≥ H_ACTIVE. The pixel is dropped (oDVAL=0), X holds, oOVF ← 1.
- Line-edge check: a VGA_HS low while READ_Request is 1 also sets oOVF.
- Channel select: p = {Y[0], X[0]} ^ BAYER_PHASE. p=00 → G, 01 → R, 10 → B, 11 → G. BAYER_PHASE=0 therefore gives G R / B G, the order the demosaic path expects.
- Width expansion: oDATA = {c[7:0], c[7:6]} (MSB replication). 8'h00 → 10'h000, 8'hFF → 10'h3FF, 8'h80 → 10'h202.
- oLVAL = 1 from the first accepted pixel of a line through its last accepted pixel; delayed like oDVAL.
- oFVAL = 1 while in S_FRAME, delayed like oDVAL.
- FS priority: FS beats a pixel in the same cycle. That pixel is dropped and the next accepted pixel is X=0, Y=0.
- Mid-operation RST: every register returns to reset immediately, state → S_IDLE. No output is produced until the next FS.

## Timing
- Reset values: oDATA=0, oDVAL=0, oLVAL=0, oFVAL=0, oX=0, oY=0, oOVF=0, state S_IDLE.
- Pipeline, fixed latency of 2 cycles from input to outputs:
  - Stage 1 registers the inputs, the accept decision, and X/Y.
  - Stage 2 registers the channel mux and the expansion into oDATA, oDVAL, oX, oY.
- Timing of registered events:
  - FS is recognised 1 cycle after the VS falling edge; counters are cleared on that cycle's edge.
  - oFVAL rises 2 cycles after FS is recognised.
- Throughput: one pixel per clock with no back-pressure. Gaps in READ_Request within a line are not allowed; a gap ends the line.
- oOVF rises 2 cycles after the offending input, aligned with the pipeline.

## Test plan
- Pattern check: reset, FS, one line of 4 pixels R=8'hFF, G=8'h80, B=8'h00, BAYER_PHASE=0 → oDATA = 202, 3FF, 202, 3FF with oX=0..3, oY=0, oDVAL=1 for 4 cycles starting 2 cycles after the first input.
- Line 1 parity: the second line with the same data → oDATA = 000, 202, 000, 202 at oY=1. Repeat with BAYER_PHASE=2'b11 → line 0 gives 202, 000, 202, 000.
- Full frame: FS plus V_ACTIVE lines of H_ACTIVE pixels → exactly 640×480 oDVAL pulses and the state ends in S_DONE. A further 481st line produces no oDVAL, and oFVAL is 0.
- Overrun: a 642-pixel line → 640 outputs, oX peaks at 639, oOVF=1. oOVF stays 1 until the next FS, then reads 0.
- Simultaneous FS and READ_Request mid-line → that pixel is dropped and the next accepted pixel reports oX=0, oY=0.
- Asynchronous RST asserted mid-line, between clock edges → all outputs 0 immediately. After release, READ_Request activity without an FS produces no oDVAL.
